// File: rtl/seg7_scan_capture_if.sv
// rtl/seg7_scan_capture_if.sv - scanned 7-segment bus in, captured BCD frame out
interface seg7_scan_capture_if #(
  parameter int NUM_DIGITS = 4
);
  logic [6:0]              seg_in;
  logic [NUM_DIGITS-1:0]   dig_sel;
  logic [4*NUM_DIGITS-1:0] bcd_out;
  logic [NUM_DIGITS-1:0]   digit_err;
  logic                    frame_valid;
  logic                    frame_ready;
  logic                    overrun;

  modport master (
    output seg_in, dig_sel, frame_ready,
    input  bcd_out, digit_err, frame_valid, overrun
  );

  modport slave (
    input  seg_in, dig_sel, frame_ready,
    output bcd_out, digit_err, frame_valid, overrun
  );
endinterface

// File: rtl/seg7_scan_capture.sv
// rtl/seg7_scan_capture.sv - debounces a multiplexed 7-segment bus and re-assembles BCD frames
module seg7_scan_capture #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  seg7_scan_capture_if.slave  bus
);
  localparam int              IW        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int              SW        = 7 + NUM_DIGITS;
  localparam logic [3:0]      STABLE_M1 = 4'(STABLE_CYCLES - 1);
  localparam logic [IW-1:0]   LAST_IDX  = IW'(NUM_DIGITS - 1);

  typedef enum logic {SYNC, CAPTURE} state_t;

  state_t                  state_q, state_d;
  logic [SW-1:0]           samp_q, samp_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] shadow_bcd_q, shadow_bcd_d;
  logic [NUM_DIGITS-1:0]   shadow_err_q, shadow_err_d;
  logic                    complete_q, complete_d;
  logic [4*NUM_DIGITS-1:0] bcd_q, bcd_d;
  logic [NUM_DIGITS-1:0]   err_q, err_d;
  logic                    valid_q, valid_d;
  logic                    overrun_q, overrun_d;

  logic [SW-1:0] samp_now;
  logic          same, stable_hit, one_hot, accept, bad_strobe;
  logic          store_en, out_free;
  logic [IW-1:0] st_idx;
  logic [3:0]    code;
  logic          code_err;

  always_comb begin
    code     = 4'hE;
    code_err = 1'b1;
    case (bus.seg_in)
      7'h3F: begin code = 4'd0; code_err = 1'b0; end
      7'h06: begin code = 4'd1; code_err = 1'b0; end
      7'h5B: begin code = 4'd2; code_err = 1'b0; end
      7'h4F: begin code = 4'd3; code_err = 1'b0; end
      7'h66: begin code = 4'd4; code_err = 1'b0; end
      7'h6D: begin code = 4'd5; code_err = 1'b0; end
      7'h7D: begin code = 4'd6; code_err = 1'b0; end
      7'h07: begin code = 4'd7; code_err = 1'b0; end
      7'h7F: begin code = 4'd8; code_err = 1'b0; end
      7'h6F: begin code = 4'd9; code_err = 1'b0; end
      7'h00: begin code = 4'hF; code_err = 1'b0; end
      default: begin code = 4'hE; code_err = 1'b1; end
    endcase
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    shadow_bcd_d = shadow_bcd_q;
    shadow_err_d = shadow_err_q;
    complete_d   = 1'b0;
    bcd_d        = bcd_q;
    err_d        = err_q;
    valid_d      = valid_q;
    overrun_d    = 1'b0;
    store_en     = 1'b0;
    st_idx       = '0;

    // Acceptance fires only on the edge where the count passes STABLE_CYCLES-1,
    // so a long dwell saturates without re-accepting.
    samp_now   = {bus.seg_in, bus.dig_sel};
    same       = (samp_now == samp_q);
    samp_d     = samp_now;
    cnt_d      = same ? ((cnt_q == 4'hF) ? 4'hF : cnt_q + 4'd1) : 4'd1;
    stable_hit = same && (cnt_q == STABLE_M1);
    one_hot    = $onehot(bus.dig_sel);
    accept     = stable_hit && one_hot;
    bad_strobe = stable_hit && !one_hot && (|bus.dig_sel);

    case (state_q)
      SYNC: begin
        if (accept && bus.dig_sel[0]) begin
          store_en = 1'b1;
          st_idx   = '0;
          if (NUM_DIGITS == 1) begin
            complete_d = 1'b1;
          end else begin
            state_d = CAPTURE;
            idx_d   = IW'(1);
          end
        end
      end
      CAPTURE: begin
        if (accept && bus.dig_sel[idx_q]) begin
          store_en = 1'b1;
          st_idx   = idx_q;
          if (idx_q == LAST_IDX) begin
            complete_d = 1'b1;
            state_d    = SYNC;
            idx_d      = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else if (accept || bad_strobe) begin
          state_d = SYNC;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = SYNC;
        idx_d   = '0;
      end
    endcase

    if (store_en) begin
      shadow_bcd_d[{st_idx, 2'b00} +: 4] = code;
      shadow_err_d[st_idx]               = code_err;
    end

    // A next-scan digit 0 needs STABLE_CYCLES >= 2 edges, so the shadow is
    // still intact on the edge after completion when it is copied out.
    out_free = !valid_q || bus.frame_ready;
    if (complete_q) begin
      if (out_free) begin
        bcd_d   = shadow_bcd_q;
        err_d   = shadow_err_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && bus.frame_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= SYNC;
      samp_q       <= '0;
      cnt_q        <= '0;
      idx_q        <= '0;
      shadow_bcd_q <= '0;
      shadow_err_q <= '0;
      complete_q   <= 1'b0;
      bcd_q        <= '0;
      err_q        <= '0;
      valid_q      <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      samp_q       <= samp_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_bcd_q <= shadow_bcd_d;
      shadow_err_q <= shadow_err_d;
      complete_q   <= complete_d;
      bcd_q        <= bcd_d;
      err_q        <= err_d;
      valid_q      <= valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bus.bcd_out     = bcd_q;
  assign bus.digit_err   = err_q;
  assign bus.frame_valid = valid_q;
  assign bus.overrun     = overrun_q;
endmodule

// File: tb/tb_seg7_scan_capture.sv
// tb/tb_seg7_scan_capture.sv - vector table, corner sequences and random scans against a frame-level model
module tb_seg7_scan_capture;
  localparam int N  = 4;
  localparam int ST = 3;

  localparam logic [6:0] P0 = 7'h3F, P1 = 7'h06, P2 = 7'h5B, P3 = 7'h4F, P4 = 7'h66;
  localparam logic [6:0] P5 = 7'h6D, P6 = 7'h7D, P7 = 7'h07, P8 = 7'h7F, P9 = 7'h6F;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg7_scan_capture_if #(.NUM_DIGITS(N)) bus ();

  seg7_scan_capture #(.NUM_DIGITS(N), .STABLE_CYCLES(ST)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_fail = 0;

  logic [6:0] legal [10];

  // reference model state
  int          m_run = 0;
  logic [10:0] m_prev = '0;
  int          m_expect = -1;
  logic [3:0]  m_dig [N];
  logic        m_derr [N];
  logic        m_pending = 1'b0;
  logic [15:0] m_frame = '0;
  logic [3:0]  m_frame_err = '0;
  logic [15:0] m_bcd = '0;
  logic [3:0]  m_err = '0;
  logic        m_valid = 1'b0;
  logic        m_ovr = 1'b0;

  // observation
  int          cyc = 0;
  int          acc_cyc = 0;
  int          rise_cyc = -1;
  int          rises = 0;
  int          ovr_cnt = 0;
  logic        prev_valid = 1'b0;
  logic [15:0] cap_bcd = '0;
  logic [3:0]  cap_err = '0;
  logic        cur_rdy = 1'b1;
  logic        rand_rdy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [4:0] decode(input logic [6:0] seg);
    for (int i = 0; i < 10; i++)
      if (seg == legal[i]) return {1'b0, 4'(i)};
    if (seg == 7'h00) return {1'b0, 4'hF};
    return {1'b1, 4'hE};
  endfunction

  task automatic model_edge(input logic [6:0] seg, input logic [N-1:0] dig, input logic rdy, input logic rst);
    int k;
    logic [4:0] dec;
    if (!rst) begin
      m_run = 0; m_prev = '0; m_expect = -1; m_pending = 1'b0;
      m_bcd = '0; m_err = '0; m_valid = 1'b0; m_ovr = 1'b0;
      return;
    end
    m_ovr = 1'b0;
    if (m_pending) begin
      if (!m_valid || rdy) begin
        m_bcd = m_frame; m_err = m_frame_err; m_valid = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    m_pending = 1'b0;

    if ({seg, dig} == m_prev) m_run++;
    else m_run = 1;
    m_prev = {seg, dig};

    if (m_run == ST && dig != '0) begin
      if ($onehot(dig)) begin
        k = 0;
        for (int i = 0; i < N; i++) if (dig[i]) k = i;
        dec = decode(seg);
        if (m_expect < 0) begin
          if (k == 0) begin
            m_dig[0] = dec[3:0]; m_derr[0] = dec[4]; m_expect = 1;
          end
        end else if (k == m_expect) begin
          m_dig[k] = dec[3:0]; m_derr[k] = dec[4]; m_expect++;
        end else begin
          m_expect = -1;
        end
        if (m_expect == N) begin
          m_pending = 1'b1;
          for (int i = 0; i < N; i++) begin
            m_frame[4*i +: 4] = m_dig[i];
            m_frame_err[i]    = m_derr[i];
          end
          m_expect = -1;
        end
      end else begin
        m_expect = -1;
      end
    end
  endtask

  task automatic step(input logic [6:0] seg, input logic [N-1:0] dig, input logic rst);
    logic r;
    r = rand_rdy ? ($urandom_range(0, 3) != 0) : cur_rdy;
    bus.seg_in      = seg;
    bus.dig_sel     = dig;
    bus.frame_ready = r;
    rst_n           = rst;
    @(posedge clk);
    model_edge(seg, dig, r, rst);
    #1;
    cyc++;
    check("bcd_out", 32'(bus.bcd_out), 32'(m_bcd));
    check("digit_err", 32'(bus.digit_err), 32'(m_err));
    check("frame_valid", 32'(bus.frame_valid), 32'(m_valid));
    check("overrun", 32'(bus.overrun), 32'(m_ovr));
    if (bus.frame_valid && !prev_valid) begin
      rises++; rise_cyc = cyc; cap_bcd = bus.bcd_out; cap_err = bus.digit_err;
    end
    if (bus.overrun) ovr_cnt++;
    prev_valid = bus.frame_valid;
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) step(7'h00, '0, 1'b1);
  endtask

  task automatic dwell(input logic [6:0] seg, input int k, input int n);
    logic [N-1:0] d;
    d = '0; d[k] = 1'b1;
    for (int i = 0; i < n; i++) step(seg, d, 1'b1);
  endtask

  task automatic scan(input logic [N-1:0][6:0] segs, input logic [N-1:0][1:0] ord, input int dw, input int gp);
    logic [N-1:0] d;
    for (int p = 0; p < N; p++) begin
      gap(gp);
      d = '0; d[ord[p]] = 1'b1;
      for (int i = 0; i < dw; i++) begin
        step(segs[ord[p]], d, 1'b1);
        if (p == N - 1 && i == ST - 1) acc_cyc = cyc;
      end
    end
  endtask

  typedef struct {
    logic [N-1:0][6:0] segs;
    logic [N-1:0][1:0] ord;
    int                exp_frames;
    logic [15:0]       exp_bcd;
    logic [3:0]        exp_err;
  } vec_t;

  vec_t vt [4];

  initial begin
    legal = '{P0, P1, P2, P3, P4, P5, P6, P7, P8, P9};
    for (int i = 0; i < N; i++) begin m_dig[i] = '0; m_derr[i] = 1'b0; end

    vt[0].segs = {P2, P0, P2, P4};        vt[0].ord = {2'd3, 2'd2, 2'd1, 2'd0};
    vt[0].exp_frames = 1; vt[0].exp_bcd = 16'h2024; vt[0].exp_err = 4'b0000;
    vt[1].segs = {7'h00, 7'h40, P7, P1};  vt[1].ord = {2'd3, 2'd2, 2'd1, 2'd0};
    vt[1].exp_frames = 1; vt[1].exp_bcd = 16'hFE71; vt[1].exp_err = 4'b0100;
    vt[2].segs = {P1, P2, P3, P4};        vt[2].ord = {2'd3, 2'd1, 2'd2, 2'd0};
    vt[2].exp_frames = 0; vt[2].exp_bcd = 16'h0000; vt[2].exp_err = 4'b0000;
    vt[3].segs = {P5, P9, P3, P8};        vt[3].ord = {2'd3, 2'd2, 2'd1, 2'd0};
    vt[3].exp_frames = 1; vt[3].exp_bcd = 16'h5938; vt[3].exp_err = 4'b0000;

    step(7'h00, '0, 1'b0);
    step(P8, 4'b0001, 1'b0);
    check("reset bcd_out", 32'(bus.bcd_out), 32'h0);
    check("reset frame_valid", 32'(bus.frame_valid), 32'h0);
    check("reset overrun", 32'(bus.overrun), 32'h0);

    for (int v = 0; v < 4; v++) begin
      rises = 0;
      scan(vt[v].segs, vt[v].ord, 8, 2);
      gap(2);
      check($sformatf("vec%0d frames", v), 32'(rises), 32'(vt[v].exp_frames));
      if (vt[v].exp_frames > 0) begin
        check($sformatf("vec%0d bcd", v), 32'(cap_bcd), 32'(vt[v].exp_bcd));
        check($sformatf("vec%0d err", v), 32'(cap_err), 32'(vt[v].exp_err));
        check($sformatf("vec%0d latency", v), 32'(rise_cyc), 32'(acc_cyc + 1));
      end
    end

    // glitch: digit1 shows "1" briefly before settling on "6"
    rises = 0;
    gap(2); dwell(P3, 0, 8); gap(2);
    dwell(P1, 1, 2); dwell(P6, 1, 6); gap(2);
    dwell(P5, 2, 8); gap(2); dwell(P9, 3, 8); gap(2);
    check("glitch frames", 32'(rises), 32'd1);
    check("glitch bcd", 32'(cap_bcd), 32'h9563);

    // backpressure over two scans
    cur_rdy = 1'b0; rises = 0;
    scan({P4, P3, P2, P1}, {2'd3, 2'd2, 2'd1, 2'd0}, 8, 2);
    gap(2);
    check("bp first valid", 32'(bus.frame_valid), 32'd1);
    check("bp first bcd", 32'(bus.bcd_out), 32'h4321);
    ovr_cnt = 0;
    scan({P8, P7, P6, P5}, {2'd3, 2'd2, 2'd1, 2'd0}, 8, 2);
    gap(2);
    check("bp overrun pulses", 32'(ovr_cnt), 32'd1);
    check("bp held bcd", 32'(bus.bcd_out), 32'h4321);
    check("bp held valid", 32'(bus.frame_valid), 32'd1);
    cur_rdy = 1'b1;
    gap(1);
    check("bp release valid", 32'(bus.frame_valid), 32'd0);

    // reset in the middle of digit 2
    rises = 0;
    gap(2); dwell(P1, 0, 8); gap(2); dwell(P2, 1, 8); gap(2); dwell(P3, 2, 4);
    step(P3, 4'b0100, 1'b0);
    check("midrst bcd", 32'(bus.bcd_out), 32'h0);
    check("midrst err", 32'(bus.digit_err), 32'h0);
    check("midrst valid", 32'(bus.frame_valid), 32'h0);
    dwell(P3, 2, 4); gap(2); dwell(P4, 3, 8); gap(2);
    check("midrst no frame", 32'(rises), 32'd0);
    scan({P0, P6, P8, P9}, {2'd3, 2'd2, 2'd1, 2'd0}, 8, 2);
    gap(2);
    check("midrst next frames", 32'(rises), 32'd1);
    check("midrst next bcd", 32'(cap_bcd), 32'h0689);

    // random scans with random ready, glitches, bad strobes and order slips
    rand_rdy = 1'b1;
    for (int s = 0; s < 60; s++) begin
      for (int p = 0; p < N; p++) begin
        int k, dw, gp, sel;
        logic [6:0] seg;
        logic [N-1:0] d;
        k   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, N - 1)) : p;
        gp  = $urandom_range(0, 2);
        dw  = $urandom_range(1, 7);
        sel = $urandom_range(0, 11);
        seg = (sel < 10) ? legal[sel] : (sel == 10 ? 7'h00 : 7'($urandom));
        d   = '0; d[k] = 1'b1;
        if ($urandom_range(0, 19) == 0) d = N'($urandom);
        gap(gp);
        if ($urandom_range(0, 4) == 0) step(7'($urandom), d, 1'b1);
        for (int i = 0; i < dw; i++) step(seg, d, 1'b1);
      end
    end
    rand_rdy = 1'b0;
    gap(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
